// File: rtl/if_id_buffer.sv
// Fetch-to-decode show-ahead queue of {instr, pc} with valid/ready handshakes and single-cycle flush.
// Optional bubble/flush statistics counters when IF_ID_BUFFER_STATS_EN is defined.
module if_id_buffer #(
    parameter int unsigned    XLEN      = 32,
    parameter int unsigned    DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013),
    parameter int unsigned    CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  in_instr_i,
    input  logic [XLEN-1:0]  in_pc_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_instr_o,
    output logic [XLEN-1:0]  out_pc_o,
    output logic [CNT_W-1:0] occupancy_o
`ifdef IF_ID_BUFFER_STATS_EN
    ,
    output logic [31:0]      bubble_cnt_o,
    output logic [31:0]      flush_cnt_o
`endif
);

    localparam int unsigned      PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [XLEN-1:0]  store_instr;

    // Explicit compare keeps wrap correct for non-power-of-2 depths.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign in_ready_o  = (count_q < DepthCnt);
    assign out_valid_o = (count_q != '0);
    assign occupancy_o = count_q;
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;
    assign store_instr = (in_instr_i == '0) ? NOP_INSTR : in_instr_i;
    assign out_instr_o = out_valid_o ? instr_q[rd_ptr_q] : NOP_INSTR;
    assign out_pc_o    = out_valid_o ? pc_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= store_instr;
            pc_q[wr_ptr_q]    <= in_pc_i;
        end
    end

`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (out_ready_i && !out_valid_o) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (flush_i)                     flush_cnt_q  <= flush_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
Parametrised fetch-to-decode pipeline buffer that replaces the single-entry IF/ID register with a DEPTH-entry show-ahead queue carrying instruction and PC.
- Valid/ready handshakes on both sides.
- Single-cycle flush for jumps and mispredicts.
- NOP substitution for empty or zero instructions.
- Sits between the fetch unit and the decode stage.

Parameters:
XLEN, 32, width of the instruction and PC fields
DEPTH, 2, number of queue entries; legal range 1..16; non-power-of-2 is allowed
NOP_INSTR, 32'h00000013, instruction presented when the queue is empty and substituted for all-zero input (addi x0,x0,0)
CNT_W, $clog2(DEPTH+1), width of the occupancy output (derived; not to be overridden)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  buffer can accept an instruction this cycle
in_instr  input  XLEN  fetched instruction
in_pc  input  XLEN  PC of the fetched instruction
flush  input  1  discard all buffered and incoming entries (jump or branch redirect)
out_valid  output  1  head entry is valid
out_ready  input  1  decode accepts the head entry (deasserted means stall)
out_instr  output  XLEN  head instruction, or NOP_INSTR when empty
out_pc  output  XLEN  head PC, or 0 when empty
occupancy  output  CNT_W  number of valid entries

Behaviour:
- Clock is clk. Reset is reset, synchronous, active-high. All state updates occur on the posedge of clk.
- Reset:
  - Read and write pointers = 0; count = 0.
  - out_valid = 0, out_instr = NOP_INSTR, out_pc = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Storage: circular array of DEPTH entries of {instr, pc}.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- in_ready = (count < DEPTH). It is registered-state-derived only, with no combinational path from out_ready. When full, a same-cycle pop does not allow a push.
- Push = in_valid & in_ready & ~flush.
  - Stores in_instr, except that in_instr == 0 is stored as NOP_INSTR with its in_pc preserved and is still counted as a valid entry.
- Pop = out_valid & out_ready & ~flush.
- Outputs are show-ahead: out_instr and out_pc are driven from the head entry (a mux on registered storage).
  - out_valid = (count != 0).
  - When count == 0: out_instr = NOP_INSTR and out_pc = 0.
- Latency: an instruction pushed into an empty buffer appears on the outputs on the following cycle. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Empty with in_valid and out_ready both high: push only. out_valid rises next cycle.
- Stall (out_ready = 0): head entry and outputs hold. Pushes continue until full.
- Flush has priority over push and pop:
  - Next cycle: count = 0, both pointers = 0, out_valid = 0, out_instr = NOP_INSTR.
  - The same-cycle input is dropped.
  - in_ready stays as computed from pre-flush count during the flush cycle; fetch must not count a flush-cycle beat as accepted.
- Reset has priority over flush.
- Reset asserted mid-operation clears all entries in one cycle, regardless of handshakes.
- occupancy = count, a registered value.

Optional Feature:
Macro IF_ID_BUFFER_STATS_EN.
- When defined, two extra output ports exist:
  - bubble_cnt (32-bit): increments each cycle with out_ready=1 and out_valid=0.
  - flush_cnt (32-bit): increments each cycle flush=1.
- Both counters wrap at 2^32-1 to 0, are cleared by reset, and do not change when reset is high.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles -> out_valid=0, out_instr=32'h00000013, out_pc=0, occupancy=0, in_ready=1.
- Fill and stall: DEPTH=2, out_ready=0, push (0x00A00093, pc 0x0) then (0x00100113, pc 0x4) -> occupancy=2, in_ready=0, head instr=0x00A00093 and pc=0x0 held; a third in_valid beat is not accepted.
- Drain order: from full, out_ready=1 for 2 cycles -> pops in order pc 0x0 then 0x4. Then out_valid=0 and out_instr=NOP.
- Zero instruction: push instr 0x00000000 at pc 0x10 -> next cycle out_valid=1, out_instr=0x00000013, out_pc=0x10.
- Flush: with occupancy=2, assert flush together with in_valid (instr 0x00000063, pc 0x20) -> next cycle occupancy=0, out_valid=0; pc 0x20 never appears at the output.
- Wrap and concurrency: DEPTH=3, run continuous push and pop for 10 beats (pc 0x0..0x24) -> output PC sequence is identical, occupancy is constant at 1 after the first beat, and no entry is lost across a pointer wrap; with IF_ID_BUFFER_STATS_EN, bubble_cnt = 1.
